// File: rtl/bandai2003_unlock_rx.sv
// Console-side receiver for the mapper unlock handshake: probe, deserialize the LSB-first reply, compare.
// Optional build macro BANDAI2003_UNLOCK_RETRY_EN re-probes up to MAX_RETRY extra times before flagging FAIL.
module bandai2003_unlock_rx #(
  parameter logic [7:0]  PROBE_ADDR = 8'hA5,
  parameter logic [17:0] PATTERN    = 18'h05140,
  parameter int          TIMEOUT    = 64,
  parameter bit          AUTO_START = 1'b1,
  parameter int          MAX_RETRY  = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       START,
  input  logic       SI,
  output logic [7:0] PADDR,
  output logic       PSTB,
  output logic       BUSY,
  output logic       UNLOCKED,
  output logic       FAIL
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_WAIT_START, S_SHIFT, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [17:0]   shreg_q, shreg_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [17:0]   frame;
  logic          can_retry;

  assign frame = {SI, shreg_q[17:1]};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        // IDLE is only ever reached from reset, so AUTO_START fires once.
        if (START || AUTO_START) state_d = S_PROBE;
      end
      S_PROBE: begin
        state_d = S_WAIT_START;
        tcnt_d  = '0;
        bcnt_d  = '0;
        shreg_d = '0;
      end
      S_WAIT_START: begin
        if (!SI) begin
          shreg_d = frame;
          bcnt_d  = 5'd1;
          state_d = S_SHIFT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TW'(TIMEOUT)) state_d = can_retry ? S_PROBE : S_ERR;
        end
      end
      S_SHIFT: begin
        shreg_d = frame;
        bcnt_d  = bcnt_q + 5'd1;
        if (bcnt_q == 5'd17) begin
          if (frame == PATTERN) state_d = S_DONE;
          else                  state_d = can_retry ? S_PROBE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (START) state_d = S_PROBE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BANDAI2003_UNLOCK_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] rcnt_q, rcnt_d;

  assign can_retry = (int'(rcnt_q) < MAX_RETRY);

  // A PROBE entered straight from WAIT_START/SHIFT is a retry; any other PROBE entry is a fresh START.
  always_comb begin
    rcnt_d = rcnt_q;
    if (state_d == S_PROBE && (state_q == S_SHIFT || state_q == S_WAIT_START))
      rcnt_d = rcnt_q + 1'b1;
    else if (state_d == S_DONE || state_d == S_PROBE)
      rcnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
`else
  logic unused_max_retry;

  assign can_retry        = 1'b0;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  assign PSTB     = (state_q == S_PROBE);
  assign PADDR    = PSTB ? PROBE_ADDR : 8'h00;
  assign BUSY     = (state_q == S_PROBE) || (state_q == S_WAIT_START) || (state_q == S_SHIFT);
  assign UNLOCKED = (state_q == S_DONE);
  assign FAIL     = (state_q == S_ERR);

endmodule

// File: tb/tb_bandai2003_unlock_rx.sv
// Scoreboard bench for bandai2003_unlock_rx: a mapper model answers each probe, and the outcome and latency are checked.
module tb_bandai2003_unlock_rx;

  localparam logic [17:0] GOOD = 18'h05140;
  localparam logic [17:0] BAD6 = 18'h05100;
`ifdef BANDAI2003_UNLOCK_RETRY_EN
  localparam int N_ATT = 4;
`else
  localparam int N_ATT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       si = 1'b1;
  logic [7:0] paddr;
  logic       pstb, busy, unlocked, failed;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    string tag;
    logic  unl;
    logic  fl;
    int    lat;
  } exp_t;

  exp_t sb_q[$];

  bandai2003_unlock_rx dut (
    .CLK      (clk),
    .RSTn     (rst_n),
    .START    (start),
    .SI       (si),
    .PADDR    (paddr),
    .PSTB     (pstb),
    .BUSY     (busy),
    .UNLOCKED (unlocked),
    .FAIL     (failed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic unl, input logic fl, input int lat);
    exp_t e;
    e.tag = tag;
    e.unl = unl;
    e.fl  = fl;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_paddr"}, paddr, 0);
    check_eq({tag, "_pstb"}, pstb, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_unlocked"}, unlocked, 0);
    check_eq({tag, "_fail"}, failed, 0);
  endtask

  // Called and returning just after a falling clock edge.
  task automatic wait_probe(output int pcyc);
    int n = 0;
    while (pstb !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("probe_seen", pstb, 1);
    check_eq("probe_addr", paddr, 32'hA5);
    check_eq("probe_busy", busy, 1);
    pcyc = cyc;
  endtask

  // Mapper model: frame bit k is presented during cycle P+1+k.
  task automatic drive_frame(input logic [17:0] f, input bit hold_high, input int start_bit);
    @(negedge clk);
    check_eq("pstb_single", pstb, 0);
    check_eq("paddr_idle", paddr, 0);
    if (!hold_high) begin
      for (int k = 0; k < 18; k++) begin
        si    = f[k];
        start = (k == start_bit);
        @(negedge clk);
      end
    end
    si    = 1'b1;
    start = 1'b0;
  endtask

  task automatic run_attempts(input logic [17:0] f, input bit hold_high, input int n_att);
    int pc;
    for (int a = 0; a < n_att; a++) begin
      if (a > 0) begin
        wait_probe(pc);
        check_eq("retry_no_fail", failed, 0);
      end
      drive_frame(f, hold_high, -1);
    end
  endtask

  task automatic wait_done(input int pcyc);
    int   n = 0;
    exp_t e;
    while (!(unlocked === 1'b1 || failed === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_pending", (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_unlocked"}, unlocked, e.unl);
      check_eq({e.tag, "_fail"}, failed, e.fl);
      check_eq({e.tag, "_latency"}, cyc - pcyc, e.lat);
      check_eq({e.tag, "_busy"}, busy, 0);
      check_eq({e.tag, "_exclusive"}, unlocked & failed, 0);
      $display("[TB] txn %s: unlocked=%0b fail=%0b latency=%0d", e.tag, unlocked, failed, cyc - pcyc);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [17:0] frame_v;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    wait_probe(p);
    push_exp("auto_good", 1'b1, 1'b0, 19);
    drive_frame(GOOD, 1'b0, -1);
    wait_done(p);

    pulse_start();
    check_eq("done_clear_unlocked", unlocked, 0);
    check_eq("restart_pstb", pstb, 1);
    wait_probe(p);
    push_exp("bit6_flip", 1'b0, 1'b1, 19 * N_ATT);
    run_attempts(BAD6, 1'b0, N_ATT);
    wait_done(p);

    pulse_start();
    check_eq("err_clear_fail", failed, 0);
    wait_probe(p);
    push_exp("timeout", 1'b0, 1'b1, 65 * N_ATT);
    run_attempts(GOOD, 1'b1, N_ATT);
    wait_done(p);

    pulse_start();
    wait_probe(p);
    push_exp("start_busy", 1'b1, 1'b0, 19);
    drive_frame(GOOD, 1'b0, 5);
    wait_done(p);
    repeat (3) begin
      @(negedge clk);
      check_eq("done_hold", unlocked, 1);
      check_eq("no_reprobe", pstb, 0);
    end

    pulse_start();
    wait_probe(p);
    frame_v = GOOD;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      si = frame_v[k];
      if (k < 9) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    si = 1'b1;
    @(negedge clk);
    start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_probe(p);
    push_exp("reset_reprobe", 1'b1, 1'b0, 19);
    drive_frame(GOOD, 1'b0, -1);
    wait_done(p);

`ifdef BANDAI2003_UNLOCK_RETRY_EN
    pulse_start();
    wait_probe(p);
    push_exp("retry_ok", 1'b1, 1'b0, 57);
    run_attempts(BAD6, 1'b0, 2);
    wait_probe(p);
    check_eq("retry_no_fail", failed, 0);
    p = p - 38;
    drive_frame(GOOD, 1'b0, -1);
    wait_done(p);

    pulse_start();
    wait_probe(p);
    push_exp("retry_exhaust", 1'b0, 1'b1, 76);
    run_attempts(BAD6, 1'b0, 4);
    wait_done(p);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
